// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of the single-request cache interface.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; grant a pending request and pulse its ack
// ISSUE | memory_sig high for one cycle toward the cache
// WAIT  | wait for finish; watchdog down-counter running
// RESP  | pulse i_rvalid or d_done for the granted port
module mem_port_arbiter #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    output logic              read_or_write,
    output logic              memory_sig,
    input  logic [DATA_W-1:0] read_data,
    input  logic              finish,
    output logic              timeout_err
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              sel_data_q, sel_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              timeout_q, timeout_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              grant_data;
    logic              grant_fetch;
    logic              grant_any;

`ifdef MEM_ARB_RR_EN
    // last_data_q = 1 when the data port won the most recent grant
    logic last_data_q;

    assign grant_data = d_req & (~i_req | ~last_data_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b1;
        end else if (state_q == IDLE && grant_any) begin
            last_data_q <= grant_data;
        end
    end
`else
    assign grant_data = d_req;
`endif

    assign grant_fetch = i_req & ~grant_data;
    assign grant_any   = i_req | d_req;

    always_comb begin
        state_d    = state_q;
        sel_data_d = sel_data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        timeout_d  = timeout_q;
        wd_cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    sel_data_d = grant_data;
                    addr_d     = grant_data ? d_addr : i_addr;
                    wdata_d    = grant_data ? d_wdata : '0;
                    rw_d       = grant_data ? ~d_we : 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wd_cnt_d = WD_LOAD;
                state_d  = WAIT;
            end
            WAIT: begin
                if (finish) begin
                    if (sel_data_q) d_rdata_d = read_data;
                    else            i_rdata_d = read_data;
                    state_d = RESP;
                end else if (WD_EN && wd_cnt_q == '0) begin
                    // hung cache: answer the port with zero data so it is not stalled forever
                    timeout_d = 1'b1;
                    if (sel_data_q) d_rdata_d = '0;
                    else            i_rdata_d = '0;
                    state_d = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q - WD_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_data_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            timeout_q  <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            timeout_q  <= timeout_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // Outputs are forced low for the whole cycle rst is high, not just after the edge
    assign i_ack         = ~rst & (state_q == IDLE) & grant_fetch;
    assign d_ack         = ~rst & (state_q == IDLE) & grant_data;
    assign memory_sig    = ~rst & (state_q == ISSUE);
    assign i_rvalid      = ~rst & (state_q == RESP) & ~sel_data_q;
    assign d_done        = ~rst & (state_q == RESP) & sel_data_q;
    assign addr          = rst ? '0 : addr_q;
    assign write_data    = rst ? '0 : wdata_q;
    assign read_or_write = ~rst & rw_q;
    assign i_rdata       = rst ? '0 : i_rdata_q;
    assign d_rdata       = rst ? '0 : d_rdata_q;
    assign timeout_err   = ~rst & timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (watchdog shortened to 16 cycles).
module tb_mem_port_arbiter;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              read_or_write;
    logic              memory_sig;
    logic [DATA_W-1:0] read_data;
    logic              finish;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;
    int n_msig = 0;
    int n_irv = 0;
    int n_ddone = 0;
    int m0;
    int rv0;
    int dd0;
    logic first_d;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ack(i_ack),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .addr(addr),
        .write_data(write_data),
        .read_or_write(read_or_write),
        .memory_sig(memory_sig),
        .read_data(read_data),
        .finish(finish),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memory_sig) n_msig++;
        if (i_rvalid)   n_irv++;
        if (d_done)     n_ddone++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {i_ack, d_ack, memory_sig, i_rvalid, d_done, read_or_write, timeout_err}, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, write_data, 0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; read_data = '0; finish = 1'b0;
        step(); step(); #1;
        chk_all_zero("reset");
        step(); rst = 1'b0;

        // single fetch, finish 5 cycles after memory_sig
        step(); i_req = 1'b1; i_addr = 27'h0000100; #1;
        chk("s1_iack", i_ack, 1); chk("s1_dack", d_ack, 0);
        step(); i_req = 1'b0; i_addr = '0; #1;
        chk("s1_msig", memory_sig, 1); chk("s1_rw", read_or_write, 1); chk("s1_addr", addr, 27'h0000100);
        repeat (4) begin step(); #1; chk("s1_wait", {memory_sig, i_rvalid}, 0); end
        step(); finish = 1'b1; read_data = 32'hDEADBEEF; #1;
        chk("s1_fin_rv", i_rvalid, 0);
        step(); finish = 1'b0; read_data = '0; #1;
        chk("s1_rvalid", i_rvalid, 1); chk("s1_rdata", i_rdata, 32'hDEADBEEF); chk("s1_ddone", d_done, 0);
        step(); #1;
        chk("s1_rv_pulse", i_rvalid, 0); chk("s1_rdata_hold", i_rdata, 32'hDEADBEEF);

        // store
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 27'h1234567; d_wdata = 32'h0BADF00D; #1;
        chk("s2_dack", d_ack, 1); chk("s2_iack", i_ack, 0);
        step(); d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; #1;
        chk("s2_msig", memory_sig, 1); chk("s2_rw", read_or_write, 0);
        chk("s2_wdata", write_data, 32'h0BADF00D); chk("s2_addr", addr, 27'h1234567);
        repeat (3) begin step(); #1; chk("s2_hold", {read_or_write, write_data}, {1'b0, 32'h0BADF00D}); end
        step(); finish = 1'b1; #1;
        chk("s2_fin_wdata", write_data, 32'h0BADF00D); chk("s2_fin_done", d_done, 0);
        step(); finish = 1'b0; #1;
        chk("s2_ddone", d_done, 1); chk("s2_irv", i_rvalid, 0);
        step();

        // simultaneous fetch and load
        m0 = n_msig;
        step(); i_req = 1'b1; i_addr = 27'h0000200; d_req = 1'b1; d_we = 1'b0; d_addr = 27'h0000ABC; #1;
        chk("s3_ack1_d", d_ack, first_d); chk("s3_ack1_i", i_ack, !first_d);
        step(); if (first_d) d_req = 1'b0; else i_req = 1'b0; #1;
        chk("s3_msig1", memory_sig, 1); chk("s3_addr1", addr, first_d ? 27'h0000ABC : 27'h0000200);
        chk("s3_rw1", read_or_write, 1); chk("s3_noack1", {i_ack, d_ack}, 0);
        step(); finish = 1'b1; read_data = first_d ? 32'h11111111 : 32'h22222222; #1;
        step(); finish = 1'b0; #1;
        chk("s3_resp1_d", d_done, first_d); chk("s3_resp1_i", i_rvalid, !first_d);
        chk("s3_resp_noack", {i_ack, d_ack}, 0);
        step(); #1;
        chk("s3_ack2_d", d_ack, !first_d); chk("s3_ack2_i", i_ack, first_d);
        step(); i_req = 1'b0; d_req = 1'b0; #1;
        chk("s3_msig2", memory_sig, 1); chk("s3_addr2", addr, first_d ? 27'h0000200 : 27'h0000ABC);
        step(); finish = 1'b1; read_data = first_d ? 32'h22222222 : 32'h11111111; #1;
        step(); finish = 1'b0; read_data = '0; #1;
        chk("s3_resp2_d", d_done, !first_d); chk("s3_resp2_i", i_rvalid, first_d);
        chk("s3_irdata", i_rdata, 32'h22222222); chk("s3_drdata", d_rdata, 32'h11111111);
        chk("s3_msig_cnt", n_msig - m0, 2);
        step();

        // finish coincident with memory_sig is ignored
        step(); i_req = 1'b1; i_addr = 27'h0000300; #1;
        chk("s4_iack", i_ack, 1);
        step(); i_req = 1'b0; finish = 1'b1; read_data = 32'hBAD0BAD0; #1;
        chk("s4_msig", memory_sig, 1);
        step(); finish = 1'b0; read_data = '0; #1;
        chk("s4_w1", i_rvalid, 0);
        repeat (2) begin step(); #1; chk("s4_wn", i_rvalid, 0); end
        step(); finish = 1'b1; read_data = 32'h33333333; #1;
        step(); finish = 1'b0; read_data = '0; #1;
        chk("s4_rvalid", i_rvalid, 1); chk("s4_rdata", i_rdata, 32'h33333333);
        step();

        // watchdog: 16 WAIT cycles with no finish
        step(); d_req = 1'b1; d_we = 1'b0; d_addr = 27'h0000400; #1;
        chk("s5_dack", d_ack, 1);
        step(); d_req = 1'b0; #1;
        chk("s5_msig", memory_sig, 1);
        repeat (15) step();
        step(); #1;
        chk("s5_w16_err", timeout_err, 0); chk("s5_w16_done", d_done, 0);
        step(); #1;
        chk("s5_done", d_done, 1); chk("s5_rdata0", d_rdata, 0); chk("s5_err", timeout_err, 1);
        step();
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 27'h0000404; d_wdata = 32'hCAFEF00D; #1;
        chk("s5b_dack", d_ack, 1);
        step(); d_req = 1'b0; #1;
        chk("s5b_wdata", write_data, 32'hCAFEF00D);
        step(); finish = 1'b1; #1;
        step(); finish = 1'b0; #1;
        chk("s5b_done", d_done, 1); chk("s5b_err_sticky", timeout_err, 1);
        step();

        // reset two cycles into WAIT
        step(); i_req = 1'b1; i_addr = 27'h0000500; #1;
        chk("s6_iack", i_ack, 1);
        step(); i_req = 1'b0; #1;
        step(); step(); rst = 1'b1; #1;
        step(); rst = 1'b0; #1;
        chk_all_zero("s6_after_rst");
        rv0 = n_irv; dd0 = n_ddone;
        step(); finish = 1'b1; read_data = 32'h55555555;
        step(); finish = 1'b0; read_data = '0;
        repeat (3) step();
        #1;
        chk("s6_no_late_rv", n_irv - rv0, 0); chk("s6_no_late_dd", n_ddone - dd0, 0);
        step(); i_req = 1'b1; i_addr = 27'h0000600; #1;
        chk("s6_iack2", i_ack, 1);
        step(); i_req = 1'b0; #1;
        chk("s6_addr2", addr, 27'h0000600);
        step(); finish = 1'b1; read_data = 32'h66666666;
        step(); finish = 1'b0; read_data = '0; #1;
        chk("s6_rvalid", i_rvalid, 1); chk("s6_rdata", i_rdata, 32'h66666666);
        step(); #1;

        chk("tot_msig", n_msig, 9);
        chk("tot_irv", n_irv, 4);
        chk("tot_ddone", n_ddone, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
